seq_alu: RTL

- Datapath ALU stage directly downstream of the ALU control decoder. It consumes the 3-bit ALU control code together with two operands.
- Single-cycle ops (add/sub/and/or/slt/not) complete with fixed latency 1.
- Logical shifts run iteratively, one bit per cycle, under a start/busy/done handshake.
- Feeds the multi-cycle datapath's ALUOut register and the branch-zero logic.

---
 rtl/seq_alu.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   ALU stage that sits downstream of the ALU control decoder. ADD, SUB, NOT,
//   AND, OR and SLT finish with a latency of one cycle. Logical shifts
//   (LSL/LSR) run one bit per cycle under a start/busy/done handshake. The
//   result feeds the multi-cycle datapath's ALUOut register and the
//   branch-zero logic.
//
// Parameters
//   WIDTH    operand/result width
//   SHAMT_W  shift-amount width (log2(WIDTH)); amount = B[SHAMT_W-1:0]
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, accepted on a clk edge while not shifting
//   ALUcnt    in   3-bit operation code
//   A, B      in   operands (A = shifted value / NOT source, B = shift amount)
//   result    out  registered result, held until the next completion
//   zero      out  registered flag, 1 iff result == 0
//   overflow  out  registered signed overflow (ADD/SUB only)
//   busy      out  high while an iterative shift is in progress
//   done      out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUcnt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_LSL = 3'b011;
    localparam logic [2:0] OP_LSR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dir_right_q;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_ovf_d;
    logic [WIDTH-1:0]   work_d;

    assign shamt    = B[SHAMT_W-1:0];
    assign is_shift = (ALUcnt == OP_LSL) || (ALUcnt == OP_LSR);
    assign sum      = A + B;
    assign diff     = A - B;

    // Single-cycle result straight from the live inputs; it is only captured
    // on the accept edge, so later input changes never reach the outputs.
    // A shift by zero also takes this path (A << 0 == A).
    always_comb begin
        alu_res_d = '0;
        alu_ovf_d = 1'b0;
        case (ALUcnt)
            OP_ADD: begin
                alu_res_d = sum;
                alu_ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = diff;
                alu_ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_NOT:  alu_res_d = ~A;
            OP_LSL:  alu_res_d = A << shamt;
            OP_LSR:  alu_res_d = A >> shamt;
            OP_AND:  alu_res_d = A & B;
            OP_OR:   alu_res_d = A | B;
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: alu_res_d = '0;
        endcase
    end

    // One-bit step of the iterative shifter, zero fill on both directions.
    assign work_d = dir_right_q ? (work_q >> 1) : (work_q << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // DONE behaves like IDLE for acceptance, which gives one
                    // non-shift op per cycle when start is held.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (start) begin
                        dir_right_q <= (ALUcnt == OP_LSR);
                        if (is_shift && (shamt != '0)) begin
                            work_q  <= A;
                            cnt_q   <= shamt;
                            busy_q  <= 1'b1;
                            state_q <= S_SHIFT;
                        end else begin
                            result_q <= alu_res_d;
                            zero_q   <= (alu_res_d == '0);
                            ovf_q    <= alu_ovf_d;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    // start is ignored here; requests during a shift are dropped.
                    work_q <= work_d;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q <= work_d;
                        zero_q   <= (work_d == '0);
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
